// File: rtl/seg_scan_mux_if.sv
// Display-side bundle of the seven-segment scanner: frame data in, per-digit drive out.
// The master drives the display value; the slave (the scanner) drives the digit lines.
interface seg_scan_mux_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0]   dp_en;
  logic                    lz_en;
  logic [3:0]              hex_out;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   sel_n;
  logic                    frame;

  modport master (
    output data, dp_en, lz_en,
    input  hex_out, dp_n, sel_n, frame
  );

  modport slave (
    input  data, dp_en, lz_en,
    output hex_out, dp_n, sel_n, frame
  );
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode seven-segment scanner with frame-consistent latching,
// per-digit decimal point, leading-zero suppression and blank gaps between digit slots.
module seg_scan_mux #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input logic           clk,
  input logic           rst,
  seg_scan_mux_if.slave bus
);
  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]        r_div;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_first;
  logic [4*NUM_DIGITS-1:0] r_shadow_data;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic                    r_shadow_lz;
  logic [3:0]              r_hex;
  logic                    r_dp_n;
  logic [NUM_DIGITS-1:0]   r_sel_n;
  logic                    r_frame;

  logic                    w_tick;
  logic                    w_wrap;
  logic                    w_load;
  logic                    w_blank;
  logic                    w_suppress;
  logic                    w_upper_zero;
  logic [NUM_DIGITS-1:0]   w_lz_mask;
  logic [NUM_DIGITS-1:0]   w_onehot;

  assign w_tick = (r_div == DIV_LAST);
  assign w_wrap = w_tick && (r_idx == IDX_LAST);
  // The first cycle after reset also loads, so the first frame shows live data.
  assign w_load = w_wrap || r_first;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div   <= '0;
      r_idx   <= '0;
      r_first <= 1'b1;
    end else begin
      r_first <= 1'b0;
      if (w_tick) begin
        r_div <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow_data <= '0;
      r_shadow_dp   <= '0;
      r_shadow_lz   <= 1'b0;
    end else if (w_load) begin
      r_shadow_data <= bus.data;
      r_shadow_dp   <= bus.dp_en;
      r_shadow_lz   <= bus.lz_en;
    end
  end

  // w_lz_mask[k] is set when digit k and every digit above it hold zero.
  // NOTE: all always_comb outputs get a default first so no path can infer a latch.
  always_comb begin
    w_lz_mask    = '0;
    w_upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      w_upper_zero = w_upper_zero && (r_shadow_data[4*k +: 4] == 4'd0);
      w_lz_mask[k] = w_upper_zero;
    end
  end

  assign w_suppress = r_shadow_lz && w_lz_mask[r_idx];
  assign w_onehot   = NUM_DIGITS'(1) << r_idx;

  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign w_blank = 1'b0;
  end else begin : g_blank
    assign w_blank = (int'(r_div) < BLANK_CYCLES);
  end

  // Registered outputs; hex_out and dp_n track the slot even while sel_n keeps it dark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hex   <= 4'd0;
      r_dp_n  <= 1'b1;
      r_sel_n <= '1;
      r_frame <= 1'b0;
    end else begin
      r_hex   <= r_shadow_data[{r_idx, 2'b00} +: 4];
      r_dp_n  <= ~r_shadow_dp[r_idx];
      r_sel_n <= (w_blank || w_suppress) ? '1 : ~w_onehot;
      r_frame <= w_load;
    end
  end

  assign bus.hex_out = r_hex;
  assign bus.dp_n    = r_dp_n;
  assign bus.sel_n   = r_sel_n;
  assign bus.frame   = r_frame;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: a cycle-level reference model checks every clock,
// plus a table of per-slot vectors and hand-written reset / frame-latch sequences.
module tb_seg_scan_mux;
  localparam int ND    = 8;
  localparam int SD    = 4;
  localparam int BC    = 1;
  localparam int FRAME = ND * SD;

  logic clk = 1'b0;
  logic rst;

  seg_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_mux #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: clock edges since reset release and the frame contents currently shown.
  int          e;
  logic [31:0] m_data;
  logic [7:0]  m_dp;
  logic        m_lz;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dp;
    logic        lz;
    int          digit;
    int          div;
    logic [7:0]  sel;
    logic [3:0]  hex;
    logic        dp_n;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e      = 0;
    m_data = '0;
    m_dp   = '0;
    m_lz   = 1'b0;
  endtask

  // Expected outputs after edge e reflect the slot position at edge e-1.
  task automatic model_check();
    int         s;
    int         idx;
    int         dv;
    logic       sup;
    logic       exp_dp_n;
    logic       exp_frame;
    logic [7:0] exp_sel;
    logic [3:0] exp_hex;
    s         = e - 1;
    dv        = s % SD;
    idx       = (s / SD) % ND;
    sup       = m_lz && (idx > 0) && ((m_data >> (4 * idx)) == 32'd0);
    exp_sel   = (dv < BC || sup) ? 8'hFF : ~(8'd1 << idx);
    exp_hex   = m_data[4*idx +: 4];
    exp_dp_n  = ~m_dp[idx];
    exp_frame = (e == 1) || (e % FRAME == 0);
    check("model_sel_n", bus.sel_n, exp_sel);
    check("model_hex", bus.hex_out, exp_hex);
    check("model_dp_n", bus.dp_n, exp_dp_n);
    check("model_frame", bus.frame, exp_frame);
    if (exp_frame) begin
      m_data = bus.data;
      m_dp   = bus.dp_en;
      m_lz   = bus.lz_en;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
    model_check();
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (bus.frame) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL frame_timeout: no frame pulse within %0d cycles", 2 * FRAME);
  endtask

  task automatic set_inputs(input logic [31:0] d, input logic [7:0] dp, input logic lz);
    bus.data  = d;
    bus.dp_en = dp;
    bus.lz_en = lz;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    set_inputs(v.data, v.dp, v.lz);
    wait_frame();
    repeat (4 * v.digit + v.div + 1) tick();
    check($sformatf("vec%0d_sel_n", n), bus.sel_n, v.sel);
    check($sformatf("vec%0d_hex", n), bus.hex_out, v.hex);
    check($sformatf("vec%0d_dp_n", n), bus.dp_n, v.dp_n);
  endtask

  task automatic random_phase(input int cycles);
    int          lead;
    logic [31:0] d;
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        lead = $urandom_range(0, 8);
        d    = $urandom;
        if (lead > 0) d = d & (32'hFFFF_FFFF >> (4 * lead));
        set_inputs(d, 8'($urandom), 1'($urandom_range(0, 1)));
      end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic scan
    vecs.push_back('{32'h12345678, 8'h00, 1'b0, 0, 1, 8'hFE, 4'h8, 1'b1});
    vecs.push_back('{32'h12345678, 8'h00, 1'b0, 3, 2, 8'hF7, 4'h5, 1'b1});
    vecs.push_back('{32'h12345678, 8'h00, 1'b0, 7, 3, 8'h7F, 4'h1, 1'b1});
    vecs.push_back('{32'h12345678, 8'h00, 1'b0, 4, 0, 8'hFF, 4'h4, 1'b1});
    // Leading-zero suppression
    vecs.push_back('{32'h00000A05, 8'h00, 1'b1, 7, 1, 8'hFF, 4'h0, 1'b1});
    vecs.push_back('{32'h00000A05, 8'h00, 1'b1, 3, 2, 8'hFF, 4'h0, 1'b1});
    vecs.push_back('{32'h00000A05, 8'h00, 1'b1, 2, 1, 8'hFB, 4'hA, 1'b1});
    vecs.push_back('{32'h00000A05, 8'h00, 1'b1, 1, 3, 8'hFD, 4'h0, 1'b1});
    vecs.push_back('{32'h00000A05, 8'h00, 1'b1, 0, 2, 8'hFE, 4'h5, 1'b1});
    // All-zero value
    vecs.push_back('{32'h00000000, 8'h00, 1'b1, 0, 1, 8'hFE, 4'h0, 1'b1});
    vecs.push_back('{32'h00000000, 8'h00, 1'b1, 1, 1, 8'hFF, 4'h0, 1'b1});
    vecs.push_back('{32'h00000000, 8'h00, 1'b0, 5, 2, 8'hDF, 4'h0, 1'b1});
    vecs.push_back('{32'h00000000, 8'h00, 1'b0, 7, 1, 8'h7F, 4'h0, 1'b1});
    // Decimal point
    vecs.push_back('{32'h12345678, 8'h04, 1'b0, 2, 1, 8'hFB, 4'h6, 1'b0});
    vecs.push_back('{32'h12345678, 8'h04, 1'b0, 3, 1, 8'hF7, 4'h5, 1'b1});
    vecs.push_back('{32'h12345678, 8'h04, 1'b0, 2, 0, 8'hFF, 4'h6, 1'b0});
    vecs.push_back('{32'h00000001, 8'h80, 1'b1, 7, 2, 8'hFF, 4'h0, 1'b0});
    vecs.push_back('{32'h00000001, 8'h80, 1'b1, 0, 1, 8'hFE, 4'h1, 1'b1});

    // Power-on reset
    rst = 1'b1;
    set_inputs(32'h12345678, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("por_sel_n", bus.sel_n, 8'hFF);
    check("por_hex", bus.hex_out, 4'h0);
    check("por_dp_n", bus.dp_n, 1'b1);
    check("por_frame", bus.frame, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick();
    check("por_first_frame", bus.frame, 1'b1);

    // Table-driven slot checks
    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Frame latch: a mid-frame change must not reach digits 3..7 of the current frame
    set_inputs(32'h12345678, 8'h00, 1'b0);
    wait_frame();
    repeat (13) tick();
    set_inputs(32'hFFFFFFFF, 8'h00, 1'b0);
    tick();
    check("latch_d3_hex", bus.hex_out, 4'h5);
    repeat (4) tick();
    check("latch_d4_hex", bus.hex_out, 4'h4);
    repeat (13) tick();
    check("latch_d7_hex", bus.hex_out, 4'h1);
    check("latch_d7_sel", bus.sel_n, 8'h7F);
    wait_frame();
    repeat (2) tick();
    check("latch_new_d0_hex", bus.hex_out, 4'hF);
    repeat (28) tick();
    check("latch_new_d7_hex", bus.hex_out, 4'hF);
    check("latch_new_d7_sel", bus.sel_n, 8'h7F);

    // Reset asserted mid-slot while digit 2 is lit with its decimal point on
    set_inputs(32'h12345678, 8'h04, 1'b0);
    wait_frame();
    repeat (10) tick();
    check("pre_rst_sel", bus.sel_n, 8'hFB);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_sel_n", bus.sel_n, 8'hFF);
    check("mid_rst_hex", bus.hex_out, 4'h0);
    check("mid_rst_dp_n", bus.dp_n, 1'b1);
    check("mid_rst_frame", bus.frame, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("held_rst_sel_n", bus.sel_n, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick();
    check("rel_frame", bus.frame, 1'b1);

    // Randomized scan against the model
    random_phase(800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Time-multiplexed scanner for a common-anode multi-digit seven-segment display.
- Cycles through digits. For each digit it presents the selected 4-bit nibble to the downstream hex-to-segment decoder and drives the active-low digit-select lines.
- Adds frame-consistent data latching, per-digit decimal point, leading-zero suppression and anti-ghosting blank gaps between digits.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (2..8).
- SCAN_DIV, 50000, clock cycles per digit slot (>= 2).
- BLANK_CYCLES, 500, cycles at the start of each slot with all digits off (0 <= BLANK_CYCLES < SCAN_DIV).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- data  in  4*NUM_DIGITS  display value; digit k uses data[4k+3:4k]; digit 0 is the rightmost digit.
- dp_en  in  NUM_DIGITS  1 = light the decimal point of digit k.
- lz_en  in  1  1 = suppress leading zeros.
- hex_out  out  4  nibble for the current digit, fed to the decoder input.
- dp_n  out  1  active-low decimal point; merged with decoder output bit 7.
- sel_n  out  NUM_DIGITS  active-low digit enables; at most one bit is low.
- frame  out  1  one-cycle pulse when the shadow registers load.

Behaviour:
- Reset is asynchronous and active-high. While rst=1 and on release:
  - div=0, idx=0.
  - shadow_data=0, shadow_dp=0.
  - hex_out=0, dp_n=1, sel_n all ones, frame=0.
- Divider:
  - div counts 0..SCAN_DIV-1 and wraps to 0.
  - tick = (div==SCAN_DIV-1).
- Digit index:
  - idx counts 0..NUM_DIGITS-1 and advances on tick.
  - On tick with idx==NUM_DIGITS-1, idx wraps to 0.
- Shadow load:
  - On a wrap tick, shadow_data<=data, shadow_dp<=dp_en, lz latched, and frame=1 for that cycle.
  - On the first cycle after reset release, shadow also loads and frame pulses, so the first frame shows live data.
  - Changes to data, dp_en or lz_en mid-frame have no effect until the next load.
- Leading-zero suppression:
  - Applies only when the latched lz=1.
  - Digit k is suppressed iff k>0, nibble k is 0, and every higher digit nibble is 0.
  - Digit 0 is never suppressed.
  - dp is ignored for this test: a suppressed digit stays dark even if its dp bit is set.
- Outputs are registered and lag the counter state by one cycle:
  - hex_out <= shadow nibble[idx].
  - dp_n <= ~shadow_dp[idx].
  - sel_n <= all ones if div < BLANK_CYCLES or digit idx is suppressed; otherwise ~(1<<idx).
  - hex_out and dp_n update every slot even while blanked; only sel_n gates visibility.
- Slot timing per digit: BLANK_CYCLES cycles dark, then SCAN_DIV-BLANK_CYCLES cycles lit. Frame period = NUM_DIGITS*SCAN_DIV.
- With BLANK_CYCLES=0, digits switch back to back with no dark gap.
- Reset asserted mid-scan: all outputs return to reset values immediately, with no partial slot completion.

Test Plan (bench parameters NUM_DIGITS=8, SCAN_DIV=4, BLANK_CYCLES=1):
1. Reset: assert rst mid-slot -> same cycle sel_n=8'hFF, dp_n=1, hex_out=0. Release -> frame pulses on the first clock.
2. Basic scan: data=32'h12345678, dp_en=0, lz_en=0. Each 4-cycle slot shows sel_n=FF for 1 cycle, then 3 cycles of (FE, hex 8), (FD, 7), (FB, 6), ..., (7F, 1), then repeats. frame pulses every 32 cycles.
3. Frame latch: change data to 32'hFFFFFFFF during digit 3 -> digits 3..7 still show the old nibbles. After the next frame pulse all digits show F.
4. Leading-zero suppression: lz_en=1, data=32'h00000A05 -> slots for digits 7..3 keep sel_n=FF throughout. Digit 2 shows A, digit 1 shows 0, digit 0 shows 5.
5. All-zero value: lz_en=1, data=0 -> only digit 0 is lit (sel_n=FE, hex 0). lz_en=0 -> all 8 digits are lit with hex 0.
6. Decimal point: dp_en=8'h04 -> dp_n=0 only during the digit-2 slot; 1 elsewhere. With dp_en=8'h80, lz_en=1 and data=1, digit 7 stays dark.
